pipe_stage_reg: RTL and testbench

Parametrised pipeline boundary register for the in-order core. It is the generalised successor to the fixed-field stage latches (IF/ID, ID/EX, EX/MEM).
- Carries an opaque WIDTH-bit payload under a valid/ready handshake.
- Has an optional 2-entry skid buffer for full throughput under backpressure.
- Flush (discard) has priority over everything except reset.
- Invalid slots present zeroed data, so a bubble is indistinguishable from a NOP.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_stage_ctrl.sv | 93 +++++++++
 rtl/pipe_stage_reg.sv | 129 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline boundary registers: state encoding and the
// payload widths each stage packs into its boundary register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int PIPE_WIDTH_DEFAULT = 64;

  // Stage payload widths; the instantiating stage packs its fields into these.
  localparam int PIPE_PC_W     = 32;
  localparam int PIPE_INSTR_W  = 32;
  localparam int PIPE_ALUSEL_W = 3;
  localparam int PIPE_ALUOP_W  = 8;
  localparam int PIPE_REG_W    = 32;
  localparam int PIPE_IFID_W   = PIPE_PC_W + PIPE_INSTR_W;
  localparam int PIPE_IDEX_W   = PIPE_PC_W + PIPE_ALUSEL_W + PIPE_ALUOP_W + 2 * PIPE_REG_W + 1;
  localparam int PIPE_EXMEM_W  = PIPE_PC_W + PIPE_REG_W + 5 + 1;

  function automatic logic state_is_full(input pipe_state_e s);
    return (s == TWO);
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Occupancy FSM for pipe_stage_reg: tracks EMPTY/ONE/TWO and emits the
// handshake outputs plus the load enables for the main and skid registers.
module pipe_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int SKID = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  input  logic flush,
  output logic in_ready,
  output logic out_valid,
  output logic load_main_in,
  output logic load_main_skid,
  output logic load_skid
);

  localparam bit SKID_EN = (SKID != 0);

  pipe_state_e state_q;
  pipe_state_e state_d;
  logic        acc_s;
  logic        pop_s;

  assign out_valid = (state_q != EMPTY);

  if (SKID_EN) begin : g_skid
    // Registered ready: only the occupancy decides, never out_ready.
    assign in_ready = ~state_is_full(state_q);
  end else begin : g_noskid
    assign in_ready = ~out_valid | out_ready;
  end

  assign acc_s = in_valid & in_ready;
  assign pop_s = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Both entries are zeroed by the datapath; an accept this cycle is dropped.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc_s) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (acc_s && (pop_s || !SKID_EN)) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end else if (acc_s) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (pop_s) begin
            state_d = EMPTY;
          end else begin
            state_d = ONE;
          end
        end
        TWO: begin
          if (pop_s) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end else begin
            state_d = TWO;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline boundary register with optional skid entry.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH       = PIPE_WIDTH_DEFAULT,
  parameter int SKID        = 1,
  parameter int ZERO_BUBBLE = 1
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             load_main_in_s;
  logic             load_main_skid_s;
  logic             load_skid_s;

  pipe_stage_ctrl #(
    .SKID(SKID)
  ) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .out_ready      (out_ready),
    .flush          (flush),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .load_main_in   (load_main_in_s),
    .load_main_skid (load_main_skid_s),
    .load_skid      (load_skid_s)
  );

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = '0;
      skid_d = '0;
    end else begin
      if (load_main_in_s) begin
        main_d = in_data;
      end else if (load_main_skid_s) begin
        main_d = skid_q;
      end else begin
        main_d = main_q;
      end
      if (load_skid_s) begin
        skid_d = in_data;
      end else begin
        skid_d = skid_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  if (ZERO_BUBBLE != 0) begin : g_zero_bubble
    // A bubble must look exactly like a NOP downstream.
    assign out_data = out_valid ? main_q : '0;
  end else begin : g_stale_bubble
    assign out_data = main_q;
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;
  logic [CNT_W-1:0] flushc_q;
  logic [CNT_W-1:0] flushc_d;

  // Saturating counters; a flush cycle is not a stall.
  always_comb begin
    if (out_valid && !out_ready && !flush && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
    if (flush && out_valid && (flushc_q != CNT_MAX)) begin
      flushc_d = flushc_q + CNT_ONE;
    end else begin
      flushc_d = flushc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= '0;
      flushc_q <= '0;
    end else begin
      stall_q  <= stall_d;
      flushc_q <= flushc_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flushc_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised bench for pipe_stage_reg: a skid instance and a no-skid instance
// share stimulus and are both checked against a queue-style occupancy model.
module tb_pipe_stage_reg;

  localparam int TW = 32;
`ifdef PIPE_STAGE_PERF_EN
  localparam int CW = 4;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [TW-1:0] in_data;
  logic          out_ready;
  logic          flush;
  logic [1:0]    ov;
  logic [1:0]    ir;
  logic [TW-1:0] od [2];
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] sc [2];
  logic [CW-1:0] fc [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: up to two queued payloads per instance, oldest at index 0.
  logic [TW-1:0] mdat [2][2];
  int            mcnt [2];
  int            m_st [2];
  int            m_fl [2];
  int            cmax;

  pipe_stage_reg #(
    .WIDTH(TW), .SKID(1), .ZERO_BUBBLE(1)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W(CW)
`endif
  ) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .flush(flush)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(sc[0]), .flush_cnt(fc[0])
`endif
  );

  pipe_stage_reg #(
    .WIDTH(TW), .SKID(0), .ZERO_BUBBLE(1)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W(CW)
`endif
  ) u_dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .flush(flush)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(sc[1]), .flush_cnt(fc[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic model_ready(input int k);
    if (k == 0) return (mcnt[0] < 2);
    else return (mcnt[1] == 0) || out_ready;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; m_st[k] = 0; m_fl[k] = 0;
      mdat[k][0] = '0; mdat[k][1] = '0;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("out_valid[%0d]", k), {63'd0, ov[k]}, {63'd0, mcnt[k] != 0});
      chk($sformatf("out_data[%0d]", k), {32'd0, od[k]}, (mcnt[k] != 0) ? {32'd0, mdat[k][0]} : 64'd0);
      chk($sformatf("in_ready[%0d]", k), {63'd0, ir[k]}, {63'd0, model_ready(k)});
`ifdef PIPE_STAGE_PERF_EN
      chk($sformatf("stall_cnt[%0d]", k), {60'd0, sc[k]}, 64'(m_st[k]));
      chk($sformatf("flush_cnt[%0d]", k), {60'd0, fc[k]}, 64'(m_fl[k]));
`endif
    end
  endtask

  task automatic model_update();
    logic rdy, acc, pop;
    if (!rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        rdy = model_ready(k);
        acc = in_valid && rdy;
        pop = (mcnt[k] != 0) && out_ready;
        if ((mcnt[k] != 0) && !out_ready && !flush && (m_st[k] < cmax)) m_st[k]++;
        if (flush && (mcnt[k] != 0) && (m_fl[k] < cmax)) m_fl[k]++;
        if (flush) begin
          mcnt[k] = 0;
        end else begin
          if (pop) begin
            mdat[k][0] = mdat[k][1];
            mcnt[k]--;
          end
          if (acc) begin
            mdat[k][mcnt[k]] = in_data;
            mcnt[k]++;
          end
        end
      end
    end
  endtask

  // Inputs are already driven (posedge+1); check at negedge, then advance the model.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v, input logic [TW-1:0] d, input logic r, input logic f);
    in_valid = v; in_data = d; out_ready = r; flush = f;
  endtask

  initial begin
`ifdef PIPE_STAGE_PERF_EN
    cmax = (1 << CW) - 1;
`else
    cmax = 65535;
`endif
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    model_reset();
    step();
    step();
    rst = 1'b1;

    // Asynchronous reset with the skid instance holding two entries.
    drive(1'b1, 32'h51, 1'b0, 1'b0); step();
    drive(1'b1, 32'h52, 1'b0, 1'b0); step();
    chk("fill_two_ready", {63'd0, ir[0]}, 64'd0);
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid[%0d]", k), {63'd0, ov[k]}, 64'd0);
      chk($sformatf("rst_data[%0d]", k), {32'd0, od[k]}, 64'd0);
      chk($sformatf("rst_ready[%0d]", k), {63'd0, ir[k]}, 64'd1);
`ifdef PIPE_STAGE_PERF_EN
      chk($sformatf("rst_stall[%0d]", k), {60'd0, sc[k]}, 64'd0);
`endif
    end
    model_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Streaming at full rate.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h11 + TW'(i), 1'b1, 1'b0);
      step();
      chk("stream_data", {32'd0, od[0]}, 64'h11 + 64'(i));
      chk("stream_ready", {63'd0, ir[0]}, 64'd1);
      chk("stream_data_n", {32'd0, od[1]}, 64'h11 + 64'(i));
    end
    drive(1'b0, '0, 1'b1, 1'b0); step();

    // Backpressure into the skid entry, then drain in order.
    drive(1'b1, 32'hA1, 1'b0, 1'b0); step();
    drive(1'b1, 32'hA2, 1'b0, 1'b0); step();
    chk("bp_ready", {63'd0, ir[0]}, 64'd0);
    chk("bp_hold", {32'd0, od[0]}, 64'hA1);
    drive(1'b0, '0, 1'b0, 1'b0); step();
    chk("bp_hold2", {32'd0, od[0]}, 64'hA1);
    drive(1'b0, '0, 1'b1, 1'b0); step();
    chk("bp_second", {32'd0, od[0]}, 64'hA2);
`ifdef PIPE_STAGE_PERF_EN
    chk("bp_stall_cnt", {60'd0, sc[0]}, 64'd2);
`endif
    step();
    chk("bp_drained", {63'd0, ov[0]}, 64'd0);

    // Flush while TWO with a colliding accept.
    drive(1'b1, 32'hB1, 1'b0, 1'b0); step();
    drive(1'b1, 32'hB2, 1'b0, 1'b0); step();
    drive(1'b1, 32'hFF, 1'b0, 1'b1); step();
    chk("flush_valid", {63'd0, ov[0]}, 64'd0);
    chk("flush_data", {32'd0, od[0]}, 64'd0);
`ifdef PIPE_STAGE_PERF_EN
    chk("flush_cnt", {60'd0, fc[0]}, 64'd1);
`endif
    drive(1'b0, '0, 1'b1, 1'b0); step(); step();

    // No-skid mode: combinational ready follows out_ready.
    drive(1'b1, 32'hC1, 1'b0, 1'b0); step();
    drive(1'b1, 32'hC2, 1'b0, 1'b0); #1;
    chk("noskid_ready_lo", {63'd0, ir[1]}, 64'd0);
    step();
    drive(1'b1, 32'hC2, 1'b1, 1'b0); #1;
    chk("noskid_ready_hi", {63'd0, ir[1]}, 64'd1);
    step();
    chk("noskid_passthru", {32'd0, od[1]}, 64'hC2);
    chk("noskid_valid", {63'd0, ov[1]}, 64'd1);
    drive(1'b0, '0, 1'b1, 1'b0); step(); step();

`ifdef PIPE_STAGE_PERF_EN
    // Saturation of the stall counter.
    drive(1'b1, 32'hD1, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("stall_sat", {60'd0, sc[0]}, 64'd15);
    for (int i = 0; i < 3; i++) step();
    chk("stall_sat_hold", {60'd0, sc[0]}, 64'd15);
    drive(1'b0, '0, 1'b1, 1'b0); step(); step();
`endif

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, TW'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
